dcache_uncache_ctrl: RTL
========================

Name: dcache_uncache_ctrl

Overview:
- Downstream consumer of the dcache uncache-check result; owns the bypass path for MMIO and device addresses.
- Accepts one LSU request at a time, when the check flags it uncached.
- Issues exactly one single-beat AXI4-lite-style read or write. Returns data or completion to the LSU, with no cache allocation.
- Sits beside the dcache refill FSM. The dcache top arbitrates the AXI port between the two.

Parameters:
- ADDR_W, 64, request/AXI address width (equals XLEN).
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  LSU request valid
- req_ready_o  out  1  request accepted this cycle
- req_addr_i  in  ADDR_W  byte address
- req_wen_i  in  1  1 = store, 0 = load
- req_wdata_i  in  DATA_W  store data, lane-aligned
- req_wstrb_i  in  DATA_W/8  store byte strobes
- req_size_i  in  3  log2 bytes (0..3)
- uncache_valid_i  in  1  from the uncache check, for req_addr_i
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  LSU takes the response
- resp_rdata_o  out  DATA_W  load data, raw bus lanes
- resp_err_o  out  1  bus returned non-OKAY
- ar_valid_o/ar_ready_i/ar_addr_o[ADDR_W]/ar_size_o[3]  AXI read address channel
- r_valid_i/r_ready_o/r_data_i[DATA_W]/r_resp_i[2]  AXI read data channel
- aw_valid_o/aw_ready_i/aw_addr_o[ADDR_W]/aw_size_o[3]  AXI write address channel
- w_valid_o/w_ready_i/w_data_o[DATA_W]/w_strb_o[DATA_W/8]  AXI write data channel
- b_valid_i/b_ready_o/b_resp_i[2]  AXI write response channel

Behaviour:
- Reset values: all valid/ready outputs 0, data/addr outputs 0, FSM = IDLE.
- req_ready_o = (state==IDLE) & uncache_valid_i. It is combinational.
- Accept occurs when req_valid_i & req_ready_o. On accept, latch addr, wen, wdata, wstrb and size.
- A request with uncache_valid_i=0 is never accepted and leaves no state.
- States and transitions:
  - IDLE: on an accepted load -> RD_ADDR; on an accepted store -> WR_REQ.
  - RD_ADDR: ar_valid_o=1 until ar_ready_i; then -> RD_DATA.
  - RD_DATA: r_ready_o=1. On r_valid_i, latch r_data_i into resp_rdata_o and set err = (r_resp_i!=0); then -> RESP.
  - WR_REQ: aw_valid_o and w_valid_o are both asserted in the first cycle.
    - Each channel drops independently after its own handshake. Done flags aw_done/w_done allow either order, or both in one cycle.
    - When both are done -> WR_RESP.
  - WR_RESP: b_ready_o=1. On b_valid_i, set err = (b_resp_i!=0); then -> RESP.
  - RESP: resp_valid_o=1, held with data stable until resp_ready_i; then -> IDLE.
- Minimum latency, accept to resp_valid_o: 3 cycles for a load, 3 cycles for a store (single-cycle ready/valid slaves).
- No request is accepted in the RESP cycle. The next accept is possible the cycle after the resp handshake.
- AXI valids never drop before their ready. Addr/data/strb/size are stable while valid is high.
- resp_rdata_o holds its last value outside RESP. For stores it is don't-care and is driven 0.
- Reset mid-transaction returns to IDLE immediately and drops all valids. Any in-flight bus beat is the system's concern, since reset is global.
- Size field: ar_size_o/aw_size_o = latched req_size_i. The address is passed unaligned; the slave uses the strobes.

Optional Feature:
- Macro: DCACHE_UNCACHE_PERF_EN.
- Defined: adds 64-bit output counters perf_rd_cnt_o and perf_wr_cnt_o.
  - Each increments on the resp handshake of a load or store respectively.
  - Each resets to 0 and wraps at 2^64.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (alongside sysconfig.v):
  - FSM state encodings: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
  - AXI resp codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - The size encodings.
- No sub-module is needed. The write AW/W done-flag join may be a small inline block; keep it single-module.

Test Plan:
- Load at 0xa000_0048, size 3, uncache_valid_i=1, slave returns r_data=0x1122334455667788 OKAY after 2 cycles -> ar_addr_o=0xa000_0048, ar_size_o=3; resp_rdata_o=0x1122334455667788, resp_err_o=0, one handshake.
- Store to 0x1000_0000, wdata=0x41 in lane 0, wstrb=0x01; aw_ready at cycle 1, w_ready at cycle 4, b OKAY -> aw_valid drops after cycle 1, w_valid held to cycle 4, exactly one resp.
- req_valid_i=1 with uncache_valid_i=0 (addr 0x8000_0000) -> req_ready_o=0, no AXI valids, FSM stays IDLE.
- Load gets r_resp=2'b11, and resp_ready_i is held low for 5 cycles -> resp_valid_o high with stable data and resp_err_o=1 for 5 cycles; returns to IDLE after the handshake.
- rst_n asserted low during RD_DATA -> all outputs 0 asynchronously. After release, a new load completes normally.
- With DCACHE_UNCACHE_PERF_EN: 3 loads and 2 stores -> perf_rd_cnt_o=3, perf_wr_cnt_o=2.

Source files
------------

// File: rtl/dcache_uncache_ctrl_pkg.sv
// Shared definitions for the dcache uncached-access controller: FSM state codes,
// AXI response codes and transfer-size encodings.
package dcache_uncache_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

    // Any non-OKAY code (including EXOKAY, which is unexpected here) is an error.
    function automatic logic axi_is_err(input logic [1:0] resp);
        return resp != AXI_OKAY;
    endfunction

endpackage

// File: rtl/dcache_uncache_ctrl.sv
// Uncached (MMIO/device) bypass path: one single-beat AXI read or write per LSU request.
// Optional DCACHE_UNCACHE_PERF_EN adds 64-bit load/store completion counters.
module dcache_uncache_ctrl
    import dcache_uncache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic                  req_wen_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_wstrb_i,
    input  logic [2:0]            req_size_i,
    input  logic                  uncache_valid_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_W-1:0]     resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_W-1:0]     ar_addr_o,
    output logic [2:0]            ar_size_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [DATA_W-1:0]     r_data_i,
    input  logic [1:0]            r_resp_i,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [ADDR_W-1:0]     aw_addr_o,
    output logic [2:0]            aw_size_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_W-1:0]     w_data_o,
    output logic [DATA_W/8-1:0]   w_strb_o,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
`ifdef DCACHE_UNCACHE_PERF_EN
    output logic [63:0]           perf_rd_cnt_o,
    output logic [63:0]           perf_wr_cnt_o,
`endif
    input  logic [1:0]            b_resp_i
);

    localparam int STRB_W = DATA_W / 8;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [2:0]        size_q;
    logic              aw_done_q, w_done_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept, aw_fin, w_fin;

    assign req_ready_o  = (state_q == ST_IDLE) & uncache_valid_i;
    assign accept       = req_valid_i & req_ready_o;

    assign ar_valid_o   = (state_q == ST_RD_ADDR);
    assign r_ready_o    = (state_q == ST_RD_DATA);
    assign aw_valid_o   = (state_q == ST_WR_REQ) & ~aw_done_q;
    assign w_valid_o    = (state_q == ST_WR_REQ) & ~w_done_q;
    assign b_ready_o    = (state_q == ST_WR_RESP);
    assign resp_valid_o = (state_q == ST_RESP);

    assign ar_addr_o    = addr_q;
    assign ar_size_o    = size_q;
    assign aw_addr_o    = addr_q;
    assign aw_size_o    = size_q;
    assign w_data_o     = wdata_q;
    assign w_strb_o     = wstrb_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // AW and W complete independently; a channel is finished once its done flag
    // is set or its handshake happens this cycle.
    assign aw_fin = aw_done_q | (aw_valid_o & aw_ready_i);
    assign w_fin  = w_done_q  | (w_valid_o  & w_ready_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept)        state_d = req_wen_i ? ST_WR_REQ : ST_RD_ADDR;
            ST_RD_ADDR: if (ar_ready_i)    state_d = ST_RD_DATA;
            ST_RD_DATA: if (r_valid_i)     state_d = ST_RESP;
            ST_WR_REQ:  if (aw_fin & w_fin) state_d = ST_WR_RESP;
            ST_WR_RESP: if (b_valid_i)     state_d = ST_RESP;
            ST_RESP:    if (resp_ready_i)  state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                wen_q   <= req_wen_i;
                wdata_q <= req_wdata_i;
                wstrb_q <= req_wstrb_i;
                size_q  <= req_size_i;
            end
            if (state_d == ST_WR_REQ) begin
                aw_done_q <= aw_fin;
                w_done_q  <= w_fin;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (r_ready_o && r_valid_i) begin
                rdata_q <= r_data_i;
                err_q   <= axi_is_err(r_resp_i);
            end
            if (b_ready_o && b_valid_i) begin
                rdata_q <= '0;
                err_q   <= axi_is_err(b_resp_i);
            end
        end
    end

`ifdef DCACHE_UNCACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_cnt_o <= '0;
            perf_wr_cnt_o <= '0;
        end else if (resp_valid_o && resp_ready_i) begin
            if (wen_q) perf_wr_cnt_o <= perf_wr_cnt_o + 64'd1;
            else       perf_rd_cnt_o <= perf_rd_cnt_o + 64'd1;
        end
    end
`endif

endmodule
